// File: rtl/menu_input_ctl.sv
// Menu mouse-input controller: synchronizes and debounces the left button,
// decodes the cursor region and issues one-cycle click pulses per region.
module menu_input_ctl #(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [11:0] TOP_X0   = 12'd312,
  parameter logic [11:0] TOP_X1   = 12'd712,
  parameter logic [11:0] TOP_Y0   = 12'd200,
  parameter logic [11:0] TOP_Y1   = 12'd300,
  parameter logic [11:0] BOT_X0   = 12'd312,
  parameter logic [11:0] BOT_X1   = 12'd712,
  parameter logic [11:0] BOT_Y0   = 12'd468,
  parameter logic [11:0] BOT_Y1   = 12'd568,
  parameter logic [11:0] START_X0 = 12'd312,
  parameter logic [11:0] START_X1 = 12'd712,
  parameter logic [11:0] START_Y0 = 12'd334,
  parameter logic [11:0] START_Y1 = 12'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        btn_left_raw,
  input  logic        is_game_on,
  output logic        top,
  output logic        bottom,
  output logic        mouse_left,
  output logic [1:0]  hover
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] RG_NONE  = 2'd0;
  localparam logic [1:0] RG_TOP   = 2'd1;
  localparam logic [1:0] RG_BOT   = 2'd2;
  localparam logic [1:0] RG_START = 2'd3;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sync1, r_sync2;
  logic          r_top, r_bottom, r_mouse_left;
  logic [1:0]    r_hover;
  logic          w_in_top, w_in_bot, w_in_start;
  logic [1:0]    w_region;

  // Two-flop synchronizer for the asynchronous button; r_sync2 is btn_sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_left_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Region decode over inclusive rectangles; start wins over top over bottom.
  always_comb begin
    w_in_top   = (xpos >= TOP_X0) && (xpos <= TOP_X1) &&
                 (ypos >= TOP_Y0) && (ypos <= TOP_Y1);
    w_in_bot   = (xpos >= BOT_X0) && (xpos <= BOT_X1) &&
                 (ypos >= BOT_Y0) && (ypos <= BOT_Y1);
    w_in_start = (xpos >= START_X0) && (xpos <= START_X1) &&
                 (ypos >= START_Y0) && (ypos <= START_Y1);
    w_region = RG_NONE;
    if (w_in_start)    w_region = RG_START;
    else if (w_in_top) w_region = RG_TOP;
    else if (w_in_bot) w_region = RG_BOT;
  end

  // Hover is the decoded region delayed by one register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hover <= RG_NONE;
    else     r_hover <= w_region;
  end

  // Debounce FSM; the region is sampled only in the cycle a press is accepted.
  // The FSM runs while the game is on so a press in flight is silently consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_top        <= 1'b0;
      r_bottom     <= 1'b0;
      r_mouse_left <= 1'b0;
    end else begin
      r_top        <= 1'b0;
      r_bottom     <= 1'b0;
      r_mouse_left <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_sync2) begin
            r_state <= PRESS_DB;
            r_cnt   <= CNT_LOAD;
          end
        end
        PRESS_DB: begin
          if (!r_sync2) begin
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_state <= HELD;
            if (!is_game_on) begin
              r_top        <= (w_region == RG_TOP);
              r_bottom     <= (w_region == RG_BOT);
              r_mouse_left <= (w_region == RG_START);
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HELD: begin
          if (!r_sync2) begin
            r_state <= RELEASE_DB;
            r_cnt   <= CNT_LOAD;
          end
        end
        RELEASE_DB: begin
          if (r_sync2) begin
            r_state <= HELD;
          end else if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign top        = r_top;
  assign bottom     = r_bottom;
  assign mouse_left = r_mouse_left;
  assign hover      = r_hover;

endmodule
